// File: rtl/cache_stats_pkg.sv
// Shared types for the cache statistics sequencer: FSM states, event ordering
// and the default number of event sources.
package cache_stats_pkg;

  typedef enum logic [1:0] {IDLE, SNAP, SEND, DONE} cs_state_t;

  typedef enum {IC_MISS, IC_CONFLICT, DC_MISS, DC_CONFLICT} cs_event_t;

  localparam int NUM_EV = 4;

endpackage

// File: rtl/cache_stats_sequencer_stat_counter.sv
// stat_counter: one saturating event counter with synchronous clear and an
// optional read-and-clear load used during the snapshot cycle.
module stat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             clear,
  input  logic             inc,
  input  logic             snap_load,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // clear wins over everything; a snapshot load keeps an event that lands in the same cycle
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (snap_load) begin
      cnt <= {{(CNT_W-1){1'b0}}, inc};
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/cache_stats_sequencer.sv
// cache_stats_sequencer: counts I$/D$ miss and conflict strobes in saturating
// counters and, on dump_req, snapshots them coherently and streams the
// snapshot over a valid/ready channel (one beat per counter, index order).
// Optional build macro CACHE_STATS_CLEAR_ON_SNAP_EN turns the snapshot into a
// read-and-clear of the live counters.
module cache_stats_sequencer #(
  parameter int CNT_W  = 32,
  parameter int NUM_EV = cache_stats_pkg::NUM_EV,
  localparam int IDX_W = (NUM_EV > 1) ? $clog2(NUM_EV) : 1
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    en,
  input  logic                    clear,
  input  logic [NUM_EV-1:0]       ev,
  input  logic                    dump_req,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [IDX_W-1:0]        out_idx,
  output logic [CNT_W-1:0]        out_data,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_EV*CNT_W-1:0] live_cnt
);

  import cache_stats_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EV - 1);

  cs_state_t        state;
  logic [CNT_W-1:0] cnt    [NUM_EV];
  logic [CNT_W-1:0] snap_q [NUM_EV];
  logic [IDX_W-1:0] next_idx;
  logic             snap_load;

  assign next_idx = out_idx + 1'b1;

`ifdef CACHE_STATS_CLEAR_ON_SNAP_EN
  assign snap_load = (state == SNAP);
`else
  assign snap_load = 1'b0;
`endif

  for (genvar gi = 0; gi < NUM_EV; gi++) begin : g_cnt
    stat_counter #(.CNT_W(CNT_W)) u_cnt (
      .CLK       (CLK),
      .nRST      (nRST),
      .clear     (clear),
      .inc       (en & ev[gi]),
      .snap_load (snap_load),
      .cnt       (cnt[gi])
    );
    assign live_cnt[gi*CNT_W +: CNT_W] = cnt[gi];
  end

  // dump sequencer: snapshot all counters in one edge, then stream them with registered outputs
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < NUM_EV; i++) snap_q[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (dump_req) begin
            state <= SNAP;
            busy  <= 1'b1;
          end
        end
        SNAP: begin
          // counters still hold their pre-edge values here, so the snapshot is coherent
          for (int i = 0; i < NUM_EV; i++) snap_q[i] <= cnt[i];
          state     <= SEND;
          out_valid <= 1'b1;
          out_idx   <= '0;
          out_data  <= cnt[0];
        end
        SEND: begin
          if (out_ready) begin
            if (out_idx == LAST_IDX) begin
              state     <= DONE;
              out_valid <= 1'b0;
              out_idx   <= '0;
              out_data  <= '0;
              done      <= 1'b1;
            end else begin
              out_idx  <= next_idx;
              out_data <= snap_q[next_idx];
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_stats_sequencer.sv
// Directed bench for cache_stats_sequencer (4-bit counters so saturation is cheap to reach).
module tb_cache_stats_sequencer;

  localparam int CNT_W  = 4;
  localparam int NUM_EV = 4;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        en = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  ev = 4'b0;
  logic        dump_req = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [1:0]  out_idx;
  logic [3:0]  out_data;
  logic        busy;
  logic        done;
  logic [15:0] live_cnt;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  cache_stats_sequencer #(.CNT_W(CNT_W), .NUM_EV(NUM_EV)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .en        (en),
    .clear     (clear),
    .ev        (ev),
    .dump_req  (dump_req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .live_cnt  (live_cnt)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    nRST = 1'b0; en = 0; clear = 0; ev = 0; dump_req = 0; out_ready = 0;
    ticks(2);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %0b/%0b want 0/0", busy, done); end
    checks++; if (out_idx !== 2'd0 || out_data !== 4'd0) begin errors++; $display("FAIL reset_idx_data got %0d/%0d want 0/0", out_idx, out_data); end
    checks++; if (live_cnt !== 16'h0000) begin errors++; $display("FAIL reset_live got %h want 0000", live_cnt); end
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_count();
    en = 1'b1; ev = 4'b0101;
    ticks(10);
    ev = 4'b0;
    checks++; if (live_cnt !== 16'h0A0A) begin errors++; $display("FAIL count_0101 got %h want 0a0a", live_cnt); end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL count_idle got v=%0b b=%0b want 0/0", out_valid, busy); end
  endtask

  task automatic test_saturate();
    clear = 1'b1; tick(); clear = 1'b0;
    checks++; if (live_cnt !== 16'h0000) begin errors++; $display("FAIL sat_clear got %h want 0000", live_cnt); end
    ev = 4'b0100; ticks(20); ev = 4'b0;
    checks++; if (live_cnt !== 16'h0F00) begin errors++; $display("FAIL sat_max got %h want 0f00", live_cnt); end
    en = 1'b0; ev = 4'b1111; ticks(3); ev = 4'b0; en = 1'b1;
    checks++; if (live_cnt !== 16'h0F00) begin errors++; $display("FAIL sat_en_off got %h want 0f00", live_cnt); end
  endtask

  task automatic test_dump();
    logic [3:0] exp_d [4];
    exp_d[0] = 4'd7; exp_d[1] = 4'd5; exp_d[2] = 4'd3; exp_d[3] = 4'd1;
    clear = 1'b1; tick(); clear = 1'b0;
    ev = 4'b1111; tick();
    ev = 4'b0111; ticks(2);
    ev = 4'b0011; ticks(2);
    ev = 4'b0001; ticks(2);
    ev = 4'b0;
    checks++; if (live_cnt !== 16'h1357) begin errors++; $display("FAIL dump_setup got %h want 1357", live_cnt); end
    out_ready = 1'b1; dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL dump_snap got b=%0b v=%0b want 1/0", busy, out_valid); end
    tick();
    ev = 4'b0001;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'(b) || out_data !== exp_d[b]) begin
        errors++; $display("FAIL dump_beat%0d got v=%0b idx=%0d data=%0d want 1/%0d/%0d", b, out_valid, out_idx, out_data, b, exp_d[b]);
      end
      tick();
      ev = 4'b0;
    end
    checks++; if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL dump_done got d=%0b v=%0b b=%0b want 1/0/1", done, out_valid, busy); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL dump_idle got d=%0b b=%0b want 0/0", done, busy); end
    checks++; if (live_cnt !== 16'h1358) begin errors++; $display("FAIL dump_live got %h want 1358", live_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_d [4];
    int nb;
    bit got_done, pending, sent_req;
    logic [1:0] p_idx;
    logic [3:0] p_data;
    exp_d[0] = 4'd8; exp_d[1] = 4'd5; exp_d[2] = 4'd3; exp_d[3] = 4'd1;
    nb = 0; got_done = 0; pending = 0; sent_req = 0; p_idx = 0; p_data = 0;
    out_ready = 1'b0; dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      tick();
      if (done === 1'b1) got_done = 1;
      if (pending) begin
        checks++;
        if (out_valid !== 1'b1 || out_idx !== p_idx || out_data !== p_data) begin
          errors++; $display("FAIL bp_hold got v=%0b idx=%0d data=%0d want 1/%0d/%0d", out_valid, out_idx, out_data, p_idx, p_data);
        end
      end
      dump_req = 1'b0;
      out_ready = c[0];
      pending = 0;
      if (out_valid === 1'b1) begin
        if (!sent_req) begin dump_req = 1'b1; sent_req = 1; end
        if (out_ready) begin
          checks++;
          if (nb > 3) begin
            errors++; $display("FAIL bp_extra_beat got beat %0d want at most 4 beats", nb + 1);
          end else if (out_idx !== 2'(nb) || out_data !== exp_d[nb]) begin
            errors++; $display("FAIL bp_beat%0d got idx=%0d data=%0d want %0d/%0d", nb, out_idx, out_data, nb, exp_d[nb]);
          end
          nb++;
        end else begin
          pending = 1; p_idx = out_idx; p_data = out_data;
        end
      end
    end
    dump_req = 1'b0;
    checks++; if (!got_done) begin errors++; $display("FAIL bp_timeout got no done want done within 40 cycles"); end
    checks++; if (nb != 4) begin errors++; $display("FAIL bp_beat_count got %0d want 4", nb); end
    out_ready = 1'b1;
    ticks(4);
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_second_req got b=%0b v=%0b want 0/0", busy, out_valid); end
  endtask

  task automatic test_clear();
    en = 1'b1; ev = 4'b0001; clear = 1'b1;
    tick();
    clear = 1'b0; ev = 4'b0;
    checks++; if (live_cnt !== 16'h0000) begin errors++; $display("FAIL clr_vs_ev got %h want 0000", live_cnt); end
    ev = 4'b1111; ticks(2); ev = 4'b0;
    checks++; if (live_cnt !== 16'h2222) begin errors++; $display("FAIL clr_setup got %h want 2222", live_cnt); end
    out_ready = 1'b1; dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    tick();
    clear = 1'b1;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'(b) || out_data !== 4'd2) begin
        errors++; $display("FAIL clr_beat%0d got v=%0b idx=%0d data=%0d want 1/%0d/2", b, out_valid, out_idx, out_data, b);
      end
      tick();
      clear = 1'b0;
    end
    checks++; if (done !== 1'b1 || live_cnt !== 16'h0000) begin errors++; $display("FAIL clr_end got d=%0b live=%h want 1/0000", done, live_cnt); end
    tick();
  endtask

  task automatic test_abort();
    bit saw;
    saw = 0;
    ev = 4'b1111; ticks(3); ev = 4'b0;
    out_ready = 1'b1; dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    ticks(2);
    checks++; if (out_valid !== 1'b1 || out_idx !== 2'd1 || out_data !== 4'd3) begin errors++; $display("FAIL abort_beat1 got v=%0b idx=%0d data=%0d want 1/1/3", out_valid, out_idx, out_data); end
    nRST = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_ctrl got v=%0b b=%0b d=%0b want 0/0/0", out_valid, busy, done); end
    checks++; if (out_idx !== 2'd0 || out_data !== 4'd0 || live_cnt !== 16'h0000) begin errors++; $display("FAIL abort_data got idx=%0d data=%0d live=%h want 0/0/0000", out_idx, out_data, live_cnt); end
    tick();
    nRST = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done === 1'b1 || out_valid === 1'b1 || busy === 1'b1) saw = 1;
    end
    checks++; if (saw) begin errors++; $display("FAIL abort_resume got activity after reset want idle"); end
  endtask

  task automatic test_snap_clear();
    logic [15:0] exp_live;
`ifdef CACHE_STATS_CLEAR_ON_SNAP_EN
    exp_live = 16'h0010;
`else
    exp_live = 16'h0050;
`endif
    en = 1'b1; ev = 4'b0010; ticks(4); ev = 4'b0;
    checks++; if (live_cnt !== 16'h0040) begin errors++; $display("FAIL snap_setup got %h want 0040", live_cnt); end
    out_ready = 1'b1; dump_req = 1'b1;
    tick();
    dump_req = 1'b0; ev = 4'b0010;
    tick();
    ev = 4'b0;
    checks++; if (live_cnt !== exp_live) begin errors++; $display("FAIL snap_live got %h want %h", live_cnt, exp_live); end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'(b) || out_data !== ((b == 1) ? 4'd4 : 4'd0)) begin
        errors++; $display("FAIL snap_beat%0d got v=%0b idx=%0d data=%0d want 1/%0d/%0d", b, out_valid, out_idx, out_data, b, (b == 1) ? 4 : 0);
      end
      tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL snap_done got %0b want 1", done); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count();
    test_saturate();
    test_dump();
    test_back_to_back();
    test_clear();
    test_abort();
    test_snap_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
